// File: rtl/sram1r1w_pl_pkg.sv
// Shared types and helpers for the sram1r1w_pl array family.
package sram_pkg;

  // Deepest supported read pipeline (core register plus one output stage).
  localparam int RD_LAT_MAX = 2;

  // Widest word the merge helper handles; callers zero-extend into it.
  localparam int W_MAX = 1024;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // Number of write lanes in a word.
  function automatic int lanes(input int w, input int b);
    return w / b;
  endfunction

  // Bitwise merge: bits set in bit_mask come from new_w, the rest from old_w.
  function automatic logic [W_MAX-1:0] mask_merge(input logic [W_MAX-1:0] old_w,
                                                  input logic [W_MAX-1:0] new_w,
                                                  input logic [W_MAX-1:0] bit_mask);
    return (old_w & ~bit_mask) | (new_w & bit_mask);
  endfunction

endpackage

// File: rtl/sram1r1w_pl_if.sv
// Request/response bundle for sram1r1w_pl: one read port, one masked write port, busy.
interface sram1r1w_pl_if #(
  parameter int N = 64,
  parameter int W = 32,
  parameter int B = 8
);
  localparam int AW    = $clog2(N);
  localparam int LANES = W / B;

  logic             i_ren;
  logic [AW-1:0]    i_raddr;
  logic             o_rvalid;
  logic [W-1:0]     o_rdata;
  logic             i_wen;
  logic [AW-1:0]    i_waddr;
  logic [LANES-1:0] i_wmask;
  logic [W-1:0]     i_wdata;
  logic             o_busy;

  modport master (
    output i_ren, i_raddr, i_wen, i_waddr, i_wmask, i_wdata,
    input  o_rvalid, o_rdata, o_busy
  );

  modport slave (
    input  i_ren, i_raddr, i_wen, i_waddr, i_wmask, i_wdata,
    output o_rvalid, o_rdata, o_busy
  );
endinterface

// File: rtl/sram1r1w_core.sv
// Bare 1R1W array: per-lane masked write, registered read (latency 1).
// Each lane is its own narrow array so byte-enable RAM inference stays simple.
// Callers guarantee addresses are in range when wen/ren are high.
module sram1r1w_core
  import sram_pkg::*;
#(
  parameter int N = 64,
  parameter int W = 32,
  parameter int B = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wen,
  input  logic [$clog2(N)-1:0]    waddr,
  input  logic [lanes(W,B)-1:0]   wmask,
  input  logic [W-1:0]            wdata,
  input  logic                    ren,
  input  logic [$clog2(N)-1:0]    raddr,
  output logic [W-1:0]            rdata
);
  localparam int LANES = lanes(W, B);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [B-1:0] mem_q [N];
    logic [B-1:0] rdata_q;

    // Lane write: only when this lane's mask bit is set.
    always_ff @(posedge clk) begin
      if (wen && wmask[gi]) begin
        mem_q[waddr] <= wdata[gi*B +: B];
      end
    end

    // Lane registered read; holds its value between reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (ren) begin
        rdata_q <= mem_q[raddr];
      end
    end

    assign rdata[gi*B +: B] = rdata_q;
  end

endmodule

// File: rtl/sram1r1w_pl.sv
// 1R1W SRAM wrapper: post-reset init sweep, masked writes, RD_LAT 1/2 read pipe.
// Optional macro SRAM1R1W_PL_BYPASS_EN: same-address read/write returns the
// merged (write-first) word; without it the read sees the pre-write word.
module sram1r1w_pl
  import sram_pkg::*;
#(
  parameter int          N        = 64,
  parameter int          W        = 32,
  parameter int          B        = 8,
  parameter int          RD_LAT   = 1,
  parameter logic [W-1:0] INIT_VAL = '0
) (
  input  logic           clk,
  input  logic           rst,
  sram1r1w_pl_if.slave   bus
);
  localparam int             AW    = $clog2(N);
  localparam int             AWP   = AW + 1;
  localparam int             LANES = lanes(W, B);
  localparam logic [AW:0]    N_EXT = AWP'(N);
  localparam logic [AW-1:0]  LAST  = AW'(N - 1);

  if (W % B != 0) begin : g_err_lane
    $error("sram1r1w_pl: W must be a multiple of B");
  end
  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_err_lat
    $error("sram1r1w_pl: RD_LAT must be 1 or 2");
  end
  if (N < 2) begin : g_err_n
    $error("sram1r1w_pl: N must be at least 2");
  end
  if (W > W_MAX) begin : g_err_w
    $error("sram1r1w_pl: W exceeds W_MAX");
  end

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy;

  assign busy       = (state_q == INIT);
  assign bus.o_busy = busy;

  // Init FSM: sweep counter walks 0..N-1 after reset, then the array is READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        if (cnt_q == LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  // FSM state register; reset restarts the sweep from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request qualification: nothing is accepted during reset or the sweep.
  logic waddr_ok, raddr_ok, wr_acc, rd_acc;
  assign waddr_ok = {1'b0, bus.i_waddr} < N_EXT;
  assign raddr_ok = {1'b0, bus.i_raddr} < N_EXT;
  assign wr_acc   = !rst && !busy && bus.i_wen && waddr_ok;
  assign rd_acc   = !rst && !busy && bus.i_ren;

  logic             core_wen;
  logic [AW-1:0]    core_waddr;
  logic [LANES-1:0] core_wmask;
  logic [W-1:0]     core_wdata;
  logic [W-1:0]     core_rdata;

  // Write mux: the sweep owns the write port until READY.
  always_comb begin
    core_wen   = 1'b0;
    core_waddr = bus.i_waddr;
    core_wmask = bus.i_wmask;
    core_wdata = bus.i_wdata;
    if (busy) begin
      core_wen   = !rst;
      core_waddr = cnt_q;
      core_wmask = '1;
      core_wdata = INIT_VAL;
    end else begin
      core_wen = wr_acc;
    end
  end

  sram1r1w_core #(
    .N (N),
    .W (W),
    .B (B)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .wen   (core_wen),
    .waddr (core_waddr),
    .wmask (core_wmask),
    .wdata (core_wdata),
    .ren   (rd_acc && raddr_ok),
    .raddr (bus.i_raddr),
    .rdata (core_rdata)
  );

  // First stage side-band: valid every accepted read; range flag only updates
  // on accepted reads so the output word holds while idle.
  logic rvalid1_q, rvalid1_d;
  logic oor_q, oor_d;
  logic [W-1:0] rd1_data;

  // Stage-1 side-band next-state.
  always_comb begin
    rvalid1_d = rd_acc;
    oor_d     = oor_q;
    if (rd_acc) begin
      oor_d = !raddr_ok;
    end
  end

  // Stage-1 side-band registers; reset clears the valid pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid1_q <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      rvalid1_q <= rvalid1_d;
      oor_q     <= oor_d;
    end
  end

`ifdef SRAM1R1W_PL_BYPASS_EN
  logic [W-1:0] wmask_bits;
  logic         byp_q, byp_d;
  logic [W-1:0] byp_wdata_q, byp_wdata_d;
  logic [W-1:0] byp_bits_q, byp_bits_d;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_mask_bits
    assign wmask_bits[gi*B +: B] = {B{bus.i_wmask[gi]}};
  end

  // Capture a colliding write so it can be merged over the old word next cycle.
  always_comb begin
    byp_d       = byp_q;
    byp_wdata_d = byp_wdata_q;
    byp_bits_d  = byp_bits_q;
    if (rd_acc) begin
      byp_d       = wr_acc && raddr_ok && (bus.i_raddr == bus.i_waddr);
      byp_wdata_d = bus.i_wdata;
      byp_bits_d  = wmask_bits;
    end
  end

  // Bypass capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_q       <= 1'b0;
      byp_wdata_q <= '0;
      byp_bits_q  <= '0;
    end else begin
      byp_q       <= byp_d;
      byp_wdata_q <= byp_wdata_d;
      byp_bits_q  <= byp_bits_d;
    end
  end

  // Stage-1 data: zero for out-of-range, merged word on collision.
  always_comb begin
    rd1_data = core_rdata;
    if (oor_q) begin
      rd1_data = '0;
    end else if (byp_q) begin
      rd1_data = W'(mask_merge(W_MAX'(core_rdata), W_MAX'(byp_wdata_q), W_MAX'(byp_bits_q)));
    end
  end
`else
  // Stage-1 data: zero for out-of-range, otherwise the pre-write array word.
  always_comb begin
    rd1_data = core_rdata;
    if (oor_q) begin
      rd1_data = '0;
    end
  end
`endif

  if (RD_LAT == 2) begin : g_lat2
    logic         rvalid2_q, rvalid2_d;
    logic [W-1:0] rdata2_q, rdata2_d;

    // Output stage next-state: load only when stage 1 holds a result.
    always_comb begin
      rvalid2_d = rvalid1_q;
      rdata2_d  = rdata2_q;
      if (rvalid1_q) begin
        rdata2_d = rd1_data;
      end
    end

    // Output stage registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        rvalid2_q <= 1'b0;
        rdata2_q  <= '0;
      end else begin
        rvalid2_q <= rvalid2_d;
        rdata2_q  <= rdata2_d;
      end
    end

    assign bus.o_rvalid = rvalid2_q;
    assign bus.o_rdata  = rdata2_q;
  end else begin : g_lat1
    assign bus.o_rvalid = rvalid1_q;
    assign bus.o_rdata  = rd1_data;
  end

`ifndef SYNTHESIS
  // Flag requests the array drops: during the sweep or with out-of-range addresses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(busy && (bus.i_ren || bus.i_wen)))
        else $warning("sram1r1w_pl: request while busy ignored");
      assert (!(!busy && bus.i_wen && !waddr_ok))
        else $warning("sram1r1w_pl: out-of-range write dropped");
      assert (!(!busy && bus.i_ren && !raddr_ok))
        else $warning("sram1r1w_pl: out-of-range read returns zero");
    end
  end
`endif

endmodule

// File: tb/tb_sram1r1w_pl.sv
// Directed bench: dut_a (N=64, RD_LAT=1) and dut_b (N=40, RD_LAT=2).
module tb_sram1r1w_pl;

  localparam logic [31:0] IV = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram1r1w_pl_if #(.N(64), .W(32), .B(8)) ifa ();
  sram1r1w_pl_if #(.N(40), .W(32), .B(8)) ifb ();

  sram1r1w_pl #(.N(64), .W(32), .B(8), .RD_LAT(1), .INIT_VAL(IV)) dut_a (
    .clk (clk), .rst (rst_a), .bus (ifa)
  );
  sram1r1w_pl #(.N(40), .W(32), .B(8), .RD_LAT(2), .INIT_VAL(IV)) dut_b (
    .clk (clk), .rst (rst_b), .bus (ifb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifa.i_ren = 0; ifa.i_raddr = '0; ifa.i_wen = 0; ifa.i_waddr = '0;
    ifa.i_wmask = '0; ifa.i_wdata = '0;
    ifb.i_ren = 0; ifb.i_raddr = '0; ifb.i_wen = 0; ifb.i_waddr = '0;
    ifb.i_wmask = '0; ifb.i_wdata = '0;
  endtask

  task automatic write_a(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] mask);
    ifa.i_wen = 1; ifa.i_waddr = addr; ifa.i_wdata = data; ifa.i_wmask = mask;
    tick();
    ifa.i_wen = 0;
    $display("a write addr %0d data %h mask %b", addr, data, mask);
  endtask

  task automatic write_b(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] mask);
    ifb.i_wen = 1; ifb.i_waddr = addr; ifb.i_wdata = data; ifb.i_wmask = mask;
    tick();
    ifb.i_wen = 0;
    $display("b write addr %0d data %h mask %b", addr, data, mask);
  endtask

  // One read on dut_a: valid before issue, after 1 edge, after 2 edges.
  task automatic read_a(input logic [5:0] addr, output logic v0, output logic v1,
                        output logic v2, output logic [31:0] d);
    v0 = ifa.o_rvalid;
    ifa.i_ren = 1; ifa.i_raddr = addr;
    tick();
    ifa.i_ren = 0;
    v1 = ifa.o_rvalid; d = ifa.o_rdata;
    tick();
    v2 = ifa.o_rvalid;
    $display("a read addr %0d data %h", addr, d);
  endtask

  // One read on dut_b: valid after 1, 2 and 3 edges; data taken after 2.
  task automatic read_b(input logic [5:0] addr, output logic v1, output logic v2,
                        output logic v3, output logic [31:0] d);
    ifb.i_ren = 1; ifb.i_raddr = addr;
    tick();
    ifb.i_ren = 0;
    v1 = ifb.o_rvalid;
    tick();
    v2 = ifb.o_rvalid; d = ifb.o_rdata;
    tick();
    v3 = ifb.o_rvalid;
    $display("b read addr %0d data %h", addr, d);
  endtask

  task automatic test_reset();
    idle_all();
    rst_a = 1; rst_b = 1;
    repeat (3) tick();
    checks++; if (ifa.o_busy !== 1'b1) begin errors++; $display("FAIL reset_busy_a got %b want 1", ifa.o_busy); end
    checks++; if (ifa.o_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid_a got %b want 0", ifa.o_rvalid); end
    checks++; if (ifa.o_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata_a got %h want 0", ifa.o_rdata); end
    checks++; if (ifb.o_busy !== 1'b1) begin errors++; $display("FAIL reset_busy_b got %b want 1", ifb.o_busy); end
    checks++; if (ifb.o_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid_b got %b want 0", ifb.o_rvalid); end
    checks++; if (ifb.o_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata_b got %h want 0", ifb.o_rdata); end
  endtask

  task automatic test_init_sweep();
    int n_a = 0, n_b = 0, guard = 0, spur = 0;
    rst_a = 0; rst_b = 0;
    while ((ifa.o_busy || ifb.o_busy) && guard < 500) begin
      if (ifa.o_busy) n_a++;
      if (ifb.o_busy) n_b++;
      if (ifa.o_rvalid || ifb.o_rvalid) spur++;
      tick();
      guard++;
    end
    $display("sweep busy cycles a %0d b %0d", n_a, n_b);
    checks++; if (n_a != 64) begin errors++; $display("FAIL sweep_len_a got %0d want 64", n_a); end
    checks++; if (n_b != 40) begin errors++; $display("FAIL sweep_len_b got %0d want 40", n_b); end
    checks++; if (spur != 0) begin errors++; $display("FAIL sweep_rvalid got %0d want 0", spur); end
  endtask

  task automatic test_init_values();
    logic v0, v1, v2; logic [31:0] d;
    logic [5:0] addrs_a [3] = '{6'd0, 6'd31, 6'd63};
    logic [5:0] addrs_b [2] = '{6'd0, 6'd39};
    foreach (addrs_a[i]) begin
      read_a(addrs_a[i], v0, v1, v2, d);
      checks++; if (d !== IV || v1 !== 1'b1) begin errors++; $display("FAIL init_a addr %0d got %h/%b want %h/1", addrs_a[i], d, v1, IV); end
    end
    foreach (addrs_b[i]) begin
      read_b(addrs_b[i], v0, v1, v2, d);
      checks++; if (d !== IV || v1 !== 1'b1) begin errors++; $display("FAIL init_b addr %0d got %h/%b want %h/1", addrs_b[i], d, v1, IV); end
    end
  endtask

  task automatic test_masked_write();
    logic v0, v1, v2; logic [31:0] d;
    write_a(6'd5, 32'hFFFF_FFFF, 4'hF);
    write_a(6'd5, 32'h1122_3344, 4'b0101);
    read_a(6'd5, v0, v1, v2, d);
    checks++; if (d !== 32'hFF22_FF44) begin errors++; $display("FAIL masked_write got %h want ff22ff44", d); end
    write_a(6'd5, 32'h0000_0000, 4'b0000);
    read_a(6'd5, v0, v1, v2, d);
    checks++; if (d !== 32'hFF22_FF44) begin errors++; $display("FAIL zero_mask got %h want ff22ff44", d); end
  endtask

  task automatic test_latency();
    logic v0, v1, v2, v3; logic [31:0] d;
    read_a(6'd5, v0, v1, v2, d);
    checks++; if ({v0, v1, v2} !== 3'b010) begin errors++; $display("FAIL lat1_valid got %b want 010", {v0, v1, v2}); end
    write_b(6'd5, 32'h0BAD_F00D, 4'hF);
    read_b(6'd5, v1, v2, v3, d);
    checks++; if ({v1, v2, v3} !== 3'b010) begin errors++; $display("FAIL lat2_valid got %b want 010", {v1, v2, v3}); end
    checks++; if (d !== 32'h0BAD_F00D) begin errors++; $display("FAIL lat2_data got %h want 0badf00d", d); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) write_a(6'(i), 32'h1000_0000 + i, 4'hF);
    for (int i = 0; i < 8; i++) write_b(6'(i), 32'h2000_0000 + i, 4'hF);
    for (int k = 0; k < 9; k++) begin
      ifa.i_ren = (k < 8); ifa.i_raddr = 6'(k);
      tick();
      if (k < 8) begin
        checks++; if (ifa.o_rvalid !== 1'b1 || ifa.o_rdata !== 32'h1000_0000 + k) begin errors++; $display("FAIL b2b_a idx %0d got %h/%b want %h/1", k, ifa.o_rdata, ifa.o_rvalid, 32'h1000_0000 + k); end
      end else begin
        checks++; if (ifa.o_rvalid !== 1'b0 || ifa.o_rdata !== 32'h1000_0007) begin errors++; $display("FAIL b2b_a_hold got %h/%b want 10000007/0", ifa.o_rdata, ifa.o_rvalid); end
      end
    end
    ifa.i_ren = 0;
    for (int k = 0; k < 10; k++) begin
      ifb.i_ren = (k < 8); ifb.i_raddr = 6'(k);
      tick();
      if (k >= 1 && k <= 8) begin
        checks++; if (ifb.o_rvalid !== 1'b1 || ifb.o_rdata !== 32'h2000_0000 + (k - 1)) begin errors++; $display("FAIL b2b_b idx %0d got %h/%b want %h/1", k - 1, ifb.o_rdata, ifb.o_rvalid, 32'h2000_0000 + (k - 1)); end
      end else begin
        checks++; if (ifb.o_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_b_idle step %0d got %b want 0", k, ifb.o_rvalid); end
      end
    end
    ifb.i_ren = 0;
    $display("back-to-back reads done");
  endtask

  task automatic test_collision();
    logic v0, v1, v2; logic [31:0] d, exp_col;
`ifdef SRAM1R1W_PL_BYPASS_EN
    exp_col = 32'h0000_BEEF;
`else
    exp_col = 32'h0000_0000;
`endif
    write_a(6'd9, 32'h0000_0000, 4'hF);
    ifa.i_wen = 1; ifa.i_waddr = 6'd9; ifa.i_wdata = 32'hDEAD_BEEF; ifa.i_wmask = 4'b0011;
    ifa.i_ren = 1; ifa.i_raddr = 6'd9;
    tick();
    idle_all();
    $display("a collision addr 9 data %h", ifa.o_rdata);
    checks++; if (ifa.o_rvalid !== 1'b1 || ifa.o_rdata !== exp_col) begin errors++; $display("FAIL collision got %h/%b want %h/1", ifa.o_rdata, ifa.o_rvalid, exp_col); end
    // Different-address write in the same cycle must not disturb the read.
    ifa.i_wen = 1; ifa.i_waddr = 6'd10; ifa.i_wdata = 32'h5555_5555; ifa.i_wmask = 4'hF;
    ifa.i_ren = 1; ifa.i_raddr = 6'd9;
    tick();
    idle_all();
    checks++; if (ifa.o_rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL after_collision got %h want 0000beef", ifa.o_rdata); end
    read_a(6'd10, v0, v1, v2, d);
    checks++; if (d !== 32'h5555_5555) begin errors++; $display("FAIL indep_write got %h want 55555555", d); end
  endtask

  task automatic test_out_of_range();
    logic v1, v2, v3; logic [31:0] d;
    write_b(6'd45, 32'hCAFE_CAFE, 4'hF);
    read_b(6'd45, v1, v2, v3, d);
    checks++; if (v2 !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL oor_read got %h/%b want 0/1", d, v2); end
    read_b(6'd13, v1, v2, v3, d);
    checks++; if (d !== IV) begin errors++; $display("FAIL oor_no_alias got %h want %h", d, IV); end
  endtask

  task automatic test_reset_mid_sweep();
    int n = 0, guard = 0;
    rst_a = 1; tick(); rst_a = 0;
    repeat (20) tick();
    rst_a = 1; tick();
    checks++; if (ifa.o_busy !== 1'b1 || ifa.o_rvalid !== 1'b0) begin errors++; $display("FAIL midsweep_rst got %b/%b want 1/0", ifa.o_busy, ifa.o_rvalid); end
    rst_a = 0;
    while (ifa.o_busy && guard < 500) begin n++; tick(); guard++; end
    $display("a restarted sweep busy cycles %0d", n);
    checks++; if (n != 64) begin errors++; $display("FAIL midsweep_len got %0d want 64", n); end
  endtask

  task automatic test_busy_requests();
    logic v0, v1, v2; logic [31:0] d;
    int guard = 0, spur = 0;
    write_a(6'd3, 32'h0000_0000, 4'hF);
    rst_a = 1; tick(); rst_a = 0;
    repeat (10) tick();
    ifa.i_wen = 1; ifa.i_waddr = 6'd3; ifa.i_wdata = 32'h1234_5678; ifa.i_wmask = 4'hF;
    ifa.i_ren = 1; ifa.i_raddr = 6'd3;
    tick();
    idle_all();
    $display("a busy-time write/read addr 3 issued");
    while (ifa.o_busy && guard < 500) begin
      if (ifa.o_rvalid) spur++;
      tick(); guard++;
    end
    checks++; if (spur != 0 || guard >= 500) begin errors++; $display("FAIL busy_rvalid got %0d valids want 0", spur); end
    read_a(6'd3, v0, v1, v2, d);
    checks++; if (d !== IV) begin errors++; $display("FAIL busy_write got %h want %h", d, IV); end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_init_values();
    test_masked_write();
    test_latency();
    test_back_to_back();
    test_collision();
    test_out_of_range();
    test_reset_mid_sweep();
    test_busy_requests();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
